// File: rtl/matrix_result_display_if.sv
// -----------------------------------------------------------------------------
// matrix_result_display_if
// Valid/ready handshake carrying one 2x2 matrix result word from the
// multiplier stage to the seven-segment display sequencer.
//
// Signals:
//   in_valid   producer has a result word
//   in_ready   consumer can accept a word
//   in_result  {r11[15:12], r12[11:8], r21[7:4], r22[3:0]}, unsigned
//   in_error   operand-range error flag, travels with in_result
//
// Modports:
//   master  producer side (drives valid/result/error, sees ready)
//   slave   consumer side (sees valid/result/error, drives ready)
// -----------------------------------------------------------------------------
interface matrix_result_display_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_result;
   logic        in_error;

   modport master (
      output in_valid,
      output in_result,
      output in_error,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_result,
      input  in_error,
      output in_ready
   );
endinterface

// File: rtl/matrix_result_display.sv
// -----------------------------------------------------------------------------
// matrix_result_display
// Takes one 2x2 matrix result word through a valid/ready handshake and shows
// its four 4-bit elements r11, r12, r21, r22 in turn on one active-high
// seven-segment digit, each for DWELL_CYCLES clocks. If the word arrived with
// the error flag set, 'E' is shown for DWELL_CYCLES instead. A one-cycle done
// pulse marks the first idle cycle after a sequence.
//
// Optional feature (macro MATRIX_DISP_BLANK_EN): inserts a blank gap of
// BLANK_CYCLES clocks between consecutive elements (not after r22 or 'E').
//
// Ports:
//   clock     system clock, rising edge
//   reset     synchronous, active-high reset; aborts any sequence
//   in_bus    slave side of the result handshake (in_ready is combinational)
//   seg       segments {g,f,e,d,c,b,a}, active-high, registered
//   dp        decimal point, high while r11 is shown, registered
//   elem_idx  element index shown (0=r11 .. 3=r22), registered
//   busy      high in any non-idle state, registered
//   done      one-cycle pulse when a sequence completes, registered
// -----------------------------------------------------------------------------
module matrix_result_display #(
   parameter int DWELL_CYCLES = 10000000,
   parameter int BLANK_CYCLES = 2500000
) (
   input  logic                          clock,
   input  logic                          reset,
   matrix_result_display_if.slave        in_bus,
   output logic [6:0]                    seg,
   output logic                          dp,
   output logic [1:0]                    elem_idx,
   output logic                          busy,
   output logic                          done
);

   // One counter serves both dwell and blank timing, so size it for the longer.
   localparam int CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
`ifdef MATRIX_DISP_BLANK_EN
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      ERR  = 2'd2
`ifdef MATRIX_DISP_BLANK_EN
      ,
      GAP  = 2'd3
`endif
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [1:0]       next_elem;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] next_cnt;
   logic [15:0]      word;
   logic [15:0]      next_word;
   logic             error;
   logic             next_error;
   logic             transfer;
   logic [6:0]       next_seg;
   logic             next_dp;
   logic             next_busy;
   logic             next_done;

   // Seven-segment encoding; values above 9 show a dash.
   function automatic logic [6:0] enc(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = 7'h40;
      endcase
      return s;
   endfunction

   // Pick element k out of the packed result word (r11 is the top nibble).
   function automatic logic [3:0] elem_of(input logic [15:0] w, input logic [1:0] k);
      logic [3:0] e;
      case (k)
         2'd0:    e = w[15:12];
         2'd1:    e = w[11:8];
         2'd2:    e = w[7:4];
         2'd3:    e = w[3:0];
         default: e = 4'h0;
      endcase
      return e;
   endfunction

   assign in_bus.in_ready = (state == IDLE) && !reset;
   assign transfer        = in_bus.in_valid && in_bus.in_ready;

   // State, counter, captured word and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         elem_idx <= 2'd0;
         cnt      <= CNT_ZERO;
         word     <= 16'h0000;
         error    <= 1'b0;
         seg      <= 7'h00;
         dp       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state    <= next_state;
         elem_idx <= next_elem;
         cnt      <= next_cnt;
         word     <= next_word;
         error    <= next_error;
         seg      <= next_seg;
         dp       <= next_dp;
         busy     <= next_busy;
         done     <= next_done;
      end
   end

   // Capture mux: the word and flag are only replaced on a transfer.
   always_comb begin
      next_word  = word;
      next_error = error;
      if (transfer) begin
         next_word  = in_bus.in_result;
         next_error = in_bus.in_error;
      end else begin
         next_word  = word;
         next_error = error;
      end
   end

   // Next-state logic; counter restarts on every state or element change.
   always_comb begin
      next_state = state;
      next_elem  = elem_idx;
      next_cnt   = cnt;
      next_done  = 1'b0;
      case (state)
         IDLE: begin
            next_elem = 2'd0;
            next_cnt  = CNT_ZERO;
            if (transfer) begin
               next_state = next_error ? ERR : SHOW;
            end else begin
               next_state = IDLE;
            end
         end
         SHOW: begin
            if (cnt == DWELL_LAST) begin
               next_cnt = CNT_ZERO;
               if (elem_idx == 2'd3) begin
                  next_state = IDLE;
                  next_elem  = 2'd0;
                  next_done  = 1'b1;
               end else begin
`ifdef MATRIX_DISP_BLANK_EN
                  next_state = GAP;
`else
                  next_state = SHOW;
`endif
                  // In the gap the index already names the upcoming element.
                  next_elem  = elem_idx + 2'd1;
               end
            end else begin
               next_cnt = cnt + CNT_ONE;
            end
         end
         ERR: begin
            if (cnt == DWELL_LAST) begin
               next_state = IDLE;
               next_elem  = 2'd0;
               next_cnt   = CNT_ZERO;
               next_done  = 1'b1;
            end else begin
               next_cnt = cnt + CNT_ONE;
            end
         end
`ifdef MATRIX_DISP_BLANK_EN
         GAP: begin
            if (cnt == BLANK_LAST) begin
               next_state = SHOW;
               next_cnt   = CNT_ZERO;
            end else begin
               next_cnt = cnt + CNT_ONE;
            end
         end
`endif
         default: begin
            next_state = IDLE;
            next_elem  = 2'd0;
            next_cnt   = CNT_ZERO;
         end
      endcase
   end

   // Output decode from the next state so the outputs register in step with it.
   always_comb begin
      next_seg  = 7'h00;
      next_dp   = 1'b0;
      next_busy = (next_state != IDLE);
      case (next_state)
         SHOW: begin
            next_seg = enc(elem_of(next_word, next_elem));
            next_dp  = (next_elem == 2'd0);
         end
         ERR: begin
            next_seg = 7'h79;
            next_dp  = 1'b0;
         end
         default: begin
            next_seg = 7'h00;
            next_dp  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_matrix_result_display.sv
// -----------------------------------------------------------------------------
// tb_matrix_result_display
// Directed bench for matrix_result_display with DWELL_CYCLES=4, BLANK_CYCLES=2.
// Outputs are sampled 1 time unit after each rising edge, where inputs are
// also changed.
// -----------------------------------------------------------------------------
module tb_matrix_result_display;
   localparam int DWELL = 4;
   localparam int BLANK = 2;

   logic       clock;
   logic       reset;
   logic [6:0] seg;
   logic       dp;
   logic [1:0] elem_idx;
   logic       busy;
   logic       done;

   int compared   = 0;
   int mismatched = 0;

   matrix_result_display_if bus ();

   matrix_result_display #(
      .DWELL_CYCLES (DWELL),
      .BLANK_CYCLES (BLANK)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .in_bus   (bus),
      .seg      (seg),
      .dp       (dp),
      .elem_idx (elem_idx),
      .busy     (busy),
      .done     (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [6:0] e_seg, input logic e_dp,
                            input logic [1:0] e_idx, input logic e_busy, input logic e_done);
      check({tag, ".seg"},  {25'd0, seg},      {25'd0, e_seg});
      check({tag, ".dp"},   {31'd0, dp},       {31'd0, e_dp});
      check({tag, ".idx"},  {30'd0, elem_idx}, {30'd0, e_idx});
      check({tag, ".busy"}, {31'd0, busy},     {31'd0, e_busy});
      check({tag, ".done"}, {31'd0, done},     {31'd0, e_done});
   endtask

   // Checks a full four-element sequence starting at its first displayed
   // cycle and returns positioned in the done cycle.
   task automatic show_seq(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
      logic [6:0] s [4];
      s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < DWELL; c++) begin
            check_out($sformatf("%s.e%0d.c%0d", tag, k, c), s[k], (k == 0), 2'(k), 1'b1, 1'b0);
            tick();
         end
`ifdef MATRIX_DISP_BLANK_EN
         if (k < 3) begin
            for (int g = 0; g < BLANK; g++) begin
               check_out($sformatf("%s.gap%0d.c%0d", tag, k, g), 7'h00, 1'b0, 2'(k + 1), 1'b1, 1'b0);
               tick();
            end
         end
`endif
      end
   endtask

   initial begin
      reset         = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_result = 16'h4280;
      bus.in_error  = 1'b0;

      // Reset held 3 cycles with in_valid high: nothing taken, ready low.
      tick(); tick(); tick();
      check("rst.ready", {31'd0, bus.in_ready}, 32'd0);
      check_out("rst", 7'h00, 1'b0, 2'd0, 1'b0, 1'b0);
      reset        = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      check("rel.ready", {31'd0, bus.in_ready}, 32'd1);
      check_out("rel", 7'h00, 1'b0, 2'd0, 1'b0, 1'b0);

      // Normal sequence 4,2,8,0.
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      show_seq("norm", 7'h66, 7'h5B, 7'h7F, 7'h3F);
      check_out("norm.done", 7'h00, 1'b0, 2'd0, 1'b0, 1'b1);
      check("norm.done.ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      check_out("norm.after", 7'h00, 1'b0, 2'd0, 1'b0, 1'b0);

      // Error word shows 'E' only.
      bus.in_valid  = 1'b1;
      bus.in_error  = 1'b1;
      bus.in_result = 16'h1111;
      tick();
      bus.in_valid = 1'b0;
      bus.in_error = 1'b0;
      for (int c = 0; c < DWELL; c++) begin
         check_out($sformatf("err.c%0d", c), 7'h79, 1'b0, 2'd0, 1'b1, 1'b0);
         tick();
      end
      check_out("err.done", 7'h00, 1'b0, 2'd0, 1'b0, 1'b1);
      tick();
      check_out("err.after", 7'h00, 1'b0, 2'd0, 1'b0, 1'b0);

      // Back-to-back: valid held, word changed while busy, second word taken
      // in the done cycle.
      bus.in_valid  = 1'b1;
      bus.in_result = 16'h1234;
      tick();
      bus.in_result = 16'h5678;
      check("b2b.ready.busy", {31'd0, bus.in_ready}, 32'd0);
      show_seq("b2b1", 7'h06, 7'h5B, 7'h4F, 7'h66);
      check_out("b2b.done", 7'h00, 1'b0, 2'd0, 1'b0, 1'b1);
      check("b2b.done.ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      bus.in_valid = 1'b0;
      show_seq("b2b2", 7'h6D, 7'h7D, 7'h07, 7'h7F);
      check_out("b2b2.done", 7'h00, 1'b0, 2'd0, 1'b0, 1'b1);
      tick();

      // Abort by reset on cycle 6 of a sequence.
      bus.in_valid  = 1'b1;
      bus.in_result = 16'h4280;
      tick();
      bus.in_valid = 1'b0;
      for (int c = 0; c < 5; c++) tick();
`ifdef MATRIX_DISP_BLANK_EN
      check_out("abort.pre", 7'h00, 1'b0, 2'd1, 1'b1, 1'b0);
`else
      check_out("abort.pre", 7'h5B, 1'b0, 2'd1, 1'b1, 1'b0);
`endif
      reset = 1'b1;
      tick();
      check_out("abort", 7'h00, 1'b0, 2'd0, 1'b0, 1'b0);
      reset = 1'b0;
      #1;
      check("abort.ready", {31'd0, bus.in_ready}, 32'd1);
      tick();
      check_out("abort.idle", 7'h00, 1'b0, 2'd0, 1'b0, 1'b0);

      // Out-of-range elements show a dash.
      bus.in_valid  = 1'b1;
      bus.in_result = 16'hC9A0;
      tick();
      bus.in_valid = 1'b0;
      show_seq("range", 7'h40, 7'h6F, 7'h40, 7'h3F);
      check_out("range.done", 7'h00, 1'b0, 2'd0, 1'b0, 1'b1);
      tick();
      check_out("range.after", 7'h00, 1'b0, 2'd0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/matrix_result_display.md
Name: matrix_result_display

Overview:
Downstream consumer of the 2x2 matrix multiplier stage. Accepts one 16-bit result word (four 4-bit elements r11, r12, r21, r22) plus an error flag through a valid/ready handshake. Shows each element in turn on a single active-high seven-segment digit for a programmable dwell time, or shows 'E' when the multiplier flagged an out-of-range operand. Returns to idle and pulses done when the sequence ends.

Parameters:
DWELL_CYCLES, 10000000, clock cycles each element (or 'E') is held on the digit; legal range >= 1; counter width $clog2(DWELL_CYCLES+1).
BLANK_CYCLES, 2500000, blank-gap length between elements; used only with MATRIX_DISP_BLANK_EN; legal range >= 1.

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  producer has a result word
in_ready  out  1  block can accept a word; combinational, equals (state==IDLE) && !reset
in_result  in  16  {r11[15:12], r12[11:8], r21[7:4], r22[3:0]}, unsigned
in_error  in  1  producer's operand-range error flag, sampled with in_result
seg  out  7  segments {g,f,e,d,c,b,a}, active-high, registered
dp  out  1  decimal point, high while r11 is shown, registered
elem_idx  out  2  index of the element shown: 0=r11, 1=r12, 2=r21, 3=r22; registered
busy  out  1  high in any non-IDLE state, registered
done  out  1  one-cycle pulse when a sequence completes, registered

Behaviour:
- Reset: state IDLE; seg=0, dp=0, elem_idx=0, busy=0, done=0; captured word and error cleared; dwell counter=0. Reset mid-sequence aborts at once: outputs hold reset values from the next cycle and the captured data is discarded.
- Transfer happens on a rising edge when in_valid && in_ready. The block registers in_result and in_error on that edge.
- States:
  - IDLE: seg=0x00, dp=0, busy=0.
  - SHOW: busy=1, elem_idx=k, seg=enc(element k).
  - ERR: busy=1, elem_idx=0, seg=0x79 ('E'), dp=0.
- Transitions:
  - IDLE to SHOW(k=0), or IDLE to ERR if the captured error is 1, on transfer.
  - The first displayed cycle is the cycle right after the transfer edge (latency 1).
  - Each SHOW element and ERR lasts exactly DWELL_CYCLES cycles.
  - SHOW(k) goes to SHOW(k+1) for k<3.
  - SHOW(3) and ERR go to IDLE.
  - done=1 for exactly the first IDLE cycle after a sequence, never otherwise.
- in_ready is high in that done cycle, so a back-to-back transfer is accepted there and display resumes the next cycle. in_valid and in_result are ignored while busy.
- Encoding enc(v):
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - 10..15 give 0x40 ('-').
  - The multiplier's legal maximum is 8; values above 9 are tolerated, not flagged.
- The dwell counter resets to 0 on every state or element change and never wraps mid-element.

Optional Feature:
- MATRIX_DISP_BLANK_EN defined: adds a GAP state between SHOW(k) and SHOW(k+1), k=0..2, lasting BLANK_CYCLES. In GAP: seg=0x00, dp=0, busy=1, elem_idx=k+1. There is no gap after SHOW(3) or after ERR.
- Not defined: no GAP state; elements follow back-to-back as specified above.

Test Plan (DWELL_CYCLES=4, BLANK_CYCLES=2):
- Reset: hold reset 3 cycles with in_valid=1 -> in_ready=0 and all outputs 0; first cycle after release -> in_ready=1, no transfer taken during reset.
- Normal: in_result=16'h4280, in_error=0 -> seg=0x66 (dp=1) 4 cycles, then 0x5B 4, 0x7F 4, 0x3F 4 with elem_idx 0..3; then done=1 for one cycle with seg=0.
- Error: in_error=1, in_result=16'h1111 -> seg=0x79, elem_idx=0 for 4 cycles, then done pulse; no digits shown.
- Back-to-back: hold in_valid=1 and change in_result mid-sequence -> changes ignored; second word accepted in the done cycle, its r11 shown the next cycle.
- Abort: assert reset on cycle 6 of a sequence -> next cycle seg=0, busy=0, done=0, in_ready=1 after release.
- Range: in_result=16'hC9A0 -> 0x40, 0x6F, 0x40, 0x3F. With MATRIX_DISP_BLANK_EN, 2 blank cycles separate each pair.
